data_stack: RTL and testbench

DATA_STACK -- requirements
Module: data_stack

---
 rtl/stack_pkg.sv | 30 +++
 rtl/stack_regfile.sv | 33 +++
 rtl/data_stack.sv | 183 ++++++++++++++++++
 tb/tb_data_stack.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and defaults for the data stack: opcodes, error codes, FSM states.
package stack_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_PUSH = 3'b001,
    OP_POP  = 3'b010,
    OP_REPL = 3'b011,
    OP_DUP  = 3'b100,
    OP_SWAP = 3'b101,
    OP_OVER = 3'b110,
    OP_ILL  = 3'b111
  } stack_op_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_OVF  = 2'b01,
    ERR_UNF  = 2'b10,
    ERR_ILL  = 2'b11
  } err_code_t;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_t;

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: the top entry lives in its own register, deeper entries in an
// array with one write port; read ports deliver top and next. No reset needed.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     top_ld_i,
  input  logic [WIDTH-1:0]         top_data_i,
  input  logic [$clog2(DEPTH)-1:0] next_addr_i,
  output logic [WIDTH-1:0]         top_o,
  output logic [WIDTH-1:0]         next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] top_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (top_ld_i) begin
      top_q <= top_data_i;
    end
  end

  assign top_o  = top_q;
  assign next_o = mem_q[next_addr_i];

endmodule

// File: rtl/data_stack.sv
// Data stack with RUN/ERR FSM and error reporting. Define DATA_STACK_EXT_OPS_EN
// to enable DUP/SWAP/OVER; otherwise those opcodes are reported as illegal.
module data_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       op_valid,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       op_ready,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           next,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic [1:0]                 err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  state_t          state_q, state_d;
  err_code_t       err_q, err_d;
  err_code_t       fault;
  logic [CW-1:0]   count_q, count_d;
  stack_op_t       op_t;
  logic            is_full;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic            top_ld;
  logic [WIDTH-1:0] top_din;
  logic [WIDTH-1:0] top_rd;
  logic [WIDTH-1:0] next_rd;
  logic [AW-1:0]   slot_below;
  logic [AW-1:0]   slot_next;

  assign op_t    = stack_op_t'(op);
  assign is_full = (count_q == FULL_CNT);

  // The array holds every entry except the top; slot_below is where the current
  // top goes when something is pushed over it, slot_next is the entry under top.
  assign slot_below = AW'(count_q - ONE);
  assign slot_next  = AW'(count_q - TWO);

  stack_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk         (clk),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .top_ld_i    (top_ld),
    .top_data_i  (top_din),
    .next_addr_i (slot_next),
    .top_o       (top_rd),
    .next_o      (next_rd)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    count_d = count_q;
    fault   = ERR_NONE;
    wr_en   = 1'b0;
    wr_addr = slot_below;
    wr_data = top_rd;
    top_ld  = 1'b0;
    top_din = push_data;

    case (state_q)
      ST_RUN: begin
        if (op_valid) begin
          case (op_t)
            OP_NOP: ;
            OP_PUSH: begin
              if (is_full) begin
                fault = ERR_OVF;
              end else begin
                wr_en   = (count_q != '0);
                top_ld  = 1'b1;
                count_d = count_q + ONE;
              end
            end
            OP_POP: begin
              if (count_q == '0) begin
                fault = ERR_UNF;
              end else begin
                top_ld  = (count_q >= TWO);
                top_din = next_rd;
                count_d = count_q - ONE;
              end
            end
            OP_REPL: begin
              if (count_q < TWO) begin
                fault = ERR_UNF;
              end else begin
                top_ld  = 1'b1;
                count_d = count_q - ONE;
              end
            end
`ifdef DATA_STACK_EXT_OPS_EN
            OP_DUP: begin
              if (is_full) begin
                fault = ERR_OVF;
              end else if (count_q == '0) begin
                fault = ERR_UNF;
              end else begin
                wr_en   = 1'b1;
                count_d = count_q + ONE;
              end
            end
            OP_SWAP: begin
              if (count_q < TWO) begin
                fault = ERR_UNF;
              end else begin
                wr_en   = 1'b1;
                wr_addr = slot_next;
                top_ld  = 1'b1;
                top_din = next_rd;
              end
            end
            OP_OVER: begin
              if (is_full) begin
                fault = ERR_OVF;
              end else if (count_q < TWO) begin
                fault = ERR_UNF;
              end else begin
                wr_en   = 1'b1;
                top_ld  = 1'b1;
                top_din = next_rd;
                count_d = count_q + ONE;
              end
            end
`endif
            default: fault = ERR_ILL;
          endcase
        end
        if (fault != ERR_NONE) begin
          err_d   = fault;
          state_d = ST_ERR;
        end
      end
      default: begin
        if (err_clr) begin
          err_d   = ERR_NONE;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      err_q   <= ERR_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign op_ready = (state_q == ST_RUN);
  assign err      = err_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = is_full;
  assign top      = (count_q == '0) ? '0 : top_rd;
  assign next     = (count_q < TWO) ? '0 : next_rd;

endmodule

// File: tb/tb_data_stack.sv
// Directed bench for data_stack: a queue-based stack model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_data_stack;

  localparam int W = 8;
  localparam int D = 8;
`ifdef DATA_STACK_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] push_data = '0;
  logic         err_clr = 1'b0;
  logic         op_ready;
  logic [W-1:0] top;
  logic [W-1:0] next;
  logic [3:0]   count;
  logic         empty;
  logic         full;
  logic [1:0]   err;

  always #5 clk = ~clk;

  data_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op        (op),
    .push_data (push_data),
    .op_ready  (op_ready),
    .err_clr   (err_clr),
    .top       (top),
    .next      (next),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .err       (err)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  logic [W-1:0] m_q[$];
  logic [1:0]   m_err = 2'd0;
  bit           m_run = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_top();
    return (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
  endfunction

  function automatic logic [W-1:0] m_next();
    return (m_q.size() > 1) ? m_q[m_q.size()-2] : '0;
  endfunction

  // Stack semantics expressed directly on a queue (back = top).
  task automatic model_step();
    int n;
    logic [1:0] f;
    logic [W-1:0] a;
    n = m_q.size();
    f = 2'd0;
    if (!rst_n) begin
      m_q.delete();
      m_err = 2'd0;
      m_run = 1'b1;
      return;
    end
    if (!m_run) begin
      if (err_clr) begin
        m_err = 2'd0;
        m_run = 1'b1;
      end
      return;
    end
    if (!op_valid) return;
    case (op)
      3'd1: if (n == D) f = 2'd1; else m_q.push_back(push_data);
      3'd2: if (n == 0) f = 2'd2; else void'(m_q.pop_back());
      3'd3: if (n < 2) f = 2'd2;
            else begin
              void'(m_q.pop_back());
              void'(m_q.pop_back());
              m_q.push_back(push_data);
            end
      3'd4: if (!EXT) f = 2'd3; else if (n == D) f = 2'd1; else if (n == 0) f = 2'd2;
            else m_q.push_back(m_q[n-1]);
      3'd5: if (!EXT) f = 2'd3; else if (n < 2) f = 2'd2;
            else begin
              a = m_q[n-1];
              m_q[n-1] = m_q[n-2];
              m_q[n-2] = a;
            end
      3'd6: if (!EXT) f = 2'd3; else if (n == D) f = 2'd1; else if (n < 2) f = 2'd2;
            else m_q.push_back(m_q[n-2]);
      3'd7: f = 2'd3;
      default: ;
    endcase
    if (f != 2'd0) begin
      m_err = f;
      m_run = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("op_ready", op_ready, m_run);
        check("err", err, m_err);
        check("count", count, m_q.size());
        check("empty", empty, m_q.size() == 0);
        check("full", full, m_q.size() == D);
        check("top", top, m_top());
        check("next", next, m_next());
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] d);
    op_valid = 1'b1;
    op = o;
    push_data = d;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op = 3'd0;
    $display("op=%0d data=%02h -> count=%0d top=%02h next=%02h err=%0d", o, d, count, top, next, err);
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    $display("err_clr -> count=%0d top=%02h err=%0d", count, top, err);
  endtask

  initial begin
    #1;
    check("rst count", count, 4'd0);
    check("rst empty", empty, 1'b1);
    check("rst full", full, 1'b0);
    check("rst err", err, 2'd0);
    check("rst op_ready", op_ready, 1'b1);
    check("rst top", top, 8'h00);
    check("rst next", next, 8'h00);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic push/pop
    do_op(3'd1, 8'h11);
    do_op(3'd1, 8'h22);
    do_op(3'd1, 8'h33);
    @(negedge clk);
    check("push3 top", top, 8'h33);
    check("push3 next", next, 8'h22);
    check("push3 count", count, 4'd3);
    do_op(3'd2, 8'h00);
    @(negedge clk);
    check("pop top", top, 8'h22);
    check("pop count", count, 4'd2);
    do_op(3'd2, 8'h00);
    do_op(3'd2, 8'h00);
    do_op(3'd0, 8'hFF);
    @(negedge clk);
    check("drained empty", empty, 1'b1);

    // Overflow at full, then recovery
    for (int i = 0; i < D; i++) do_op(3'd1, W'(8'hA0 + i));
    @(negedge clk);
    check("fill full", full, 1'b1);
    do_op(3'd1, 8'hAA);
    @(negedge clk);
    check("ovf err", err, 2'd1);
    check("ovf op_ready", op_ready, 1'b0);
    check("ovf full", full, 1'b1);
    check("ovf top", top, 8'hA7);
    clr();
    @(negedge clk);
    check("clr err", err, 2'd0);
    check("clr op_ready", op_ready, 1'b1);
    check("clr count", count, 4'd8);
    check("clr top", top, 8'hA7);
    check("clr next", next, 8'hA6);
    clr();
    for (int i = 0; i < D; i++) do_op(3'd2, 8'h00);

    // Underflow, ops ignored in ERR, including during the clearing cycle
    do_op(3'd2, 8'h00);
    @(negedge clk);
    check("unf err", err, 2'd2);
    check("unf count", count, 4'd0);
    do_op(3'd1, 8'h55);
    @(negedge clk);
    check("err ignore count", count, 4'd0);
    err_clr = 1'b1;
    op_valid = 1'b1;
    op = 3'd1;
    push_data = 8'h66;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    op_valid = 1'b0;
    op = 3'd0;
    @(negedge clk);
    check("clr+op count", count, 4'd0);
    check("clr+op err", err, 2'd0);

    // REPL
    do_op(3'd1, 8'h05);
    do_op(3'd1, 8'h07);
    do_op(3'd3, 8'h0C);
    @(negedge clk);
    check("repl count", count, 4'd1);
    check("repl top", top, 8'h0C);
    do_op(3'd3, 8'h44);
    @(negedge clk);
    check("repl unf err", err, 2'd2);
    check("repl unf top", top, 8'h0C);
    clr();
    do_op(3'd2, 8'h00);

    // Extended ops (or their illegal handling)
    do_op(3'd1, 8'h01);
    do_op(3'd1, 8'h02);
    do_op(3'd5, 8'h00);
    @(negedge clk);
`ifdef DATA_STACK_EXT_OPS_EN
    check("swap top", top, 8'h01);
    check("swap next", next, 8'h02);
`else
    check("swap ill err", err, 2'd3);
    check("swap ill top", top, 8'h02);
    check("swap ill next", next, 8'h01);
    clr();
`endif
    do_op(3'd4, 8'h00);
    @(negedge clk);
`ifdef DATA_STACK_EXT_OPS_EN
    check("dup count", count, 4'd3);
    check("dup top", top, 8'h01);
    check("dup next", next, 8'h01);
`else
    check("dup ill err", err, 2'd3);
    check("dup ill count", count, 4'd2);
    check("dup ill top", top, 8'h02);
`endif
    if (!m_run) clr();
    do_op(3'd6, 8'h00);
    if (!m_run) clr();
    while (m_q.size() < D) do_op(3'd1, W'(8'h50 + m_q.size()));
    do_op(3'd4, 8'h00);
    if (!m_run) clr();
    do_op(3'd6, 8'h00);
    if (!m_run) clr();
    do_op(3'd5, 8'h00);
    if (!m_run) clr();

    // Illegal opcode
    do_op(3'd7, 8'h00);
    @(negedge clk);
    check("ill err", err, 2'd3);
    check("ill count", count, 4'd8);
    clr();
    while (m_q.size() > 0) do_op(3'd2, 8'h00);

    // Asynchronous reset mid-cycle with an operation pending
    for (int i = 0; i < 5; i++) do_op(3'd1, W'(8'h10 + i));
    @(negedge clk);
    check("pre-rst count", count, 4'd5);
    @(posedge clk);
    #3;
    op_valid = 1'b1;
    op = 3'd1;
    push_data = 8'h77;
    rst_n = 1'b0;
    #1;
    check("async rst count", count, 4'd0);
    check("async rst empty", empty, 1'b1);
    check("async rst top", top, 8'h00);
    @(negedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op = 3'd0;
    rst_n = 1'b1;
    do_op(3'd1, 8'h3C);
    @(negedge clk);
    check("post-rst top", top, 8'h3C);
    check("post-rst count", count, 4'd1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
